// File: rtl/fp_multiply_nr_pipe_pkg.sv
// rtl/fp_multiply_nr_pipe_pkg.sv - shared formats, rounding modes and flag layout for the FP multiply pipe
package fpNPkg;

  localparam int FP16_EMSB  = 4;
  localparam int FP16_FMSB  = 9;
  localparam int FP32_EMSB  = 7;
  localparam int FP32_FMSB  = 22;
  localparam int FP64_EMSB  = 10;
  localparam int FP64_FMSB  = 51;
  localparam int FP128_EMSB = 14;
  localparam int FP128_FMSB = 111;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // Widest-format record; narrower formats use the low-order bits of each field.
  typedef struct packed {
    logic                  sign;
    logic [FP128_EMSB:0]   exp;
    logic [FP128_FMSB:0]   sig;
  } fp_max_t;

  // Canonical qNaN right-aligned in 128 bits: exponent all ones plus fraction MSB.
  function automatic logic [127:0] canon_qnan(input int emsb, input int fmsb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i <= emsb + 1; i++) r[fmsb + i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_multiply_nr_pipe_round.sv
// rtl/fp_multiply_nr_pipe_round.sv - rounding, carry re-normalisation and packing of a finite product
module fp_round_pack
  import fpNPkg::*;
#(
  parameter int EMSB  = 10,
  parameter int FMSB  = 51,
  parameter int FPWID = EMSB + FMSB + 3
) (
  input  logic             sign,
  input  logic [EMSB+1:0]  exp,
  input  logic [FMSB+1:0]  sig,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  input  logic [2:0]       rm,
  output logic [FPWID-1:0] res,
  output logic             overflow,
  output logic             inexact
);

  localparam int E = EMSB + 1;
  localparam int M = FMSB + 2;

  logic         inc;
  logic         to_inf;
  logic         lost;
  logic [M:0]   sum;
  logic [E:0]   exp_r;
  logic [M-1:0] sig_r;

  always_comb begin
    lost = g | r | s;
    case (rm)
      RM_RTZ:  begin inc = 1'b0;         to_inf = 1'b0;  end
      RM_RDN:  begin inc = sign & lost;  to_inf = sign;  end
      RM_RUP:  begin inc = ~sign & lost; to_inf = ~sign; end
      RM_RMM:  begin inc = g;            to_inf = 1'b1;  end
      default: begin inc = g & (r | s | sig[0]); to_inf = 1'b1; end
    endcase

    sum = {1'b0, sig} + {{M{1'b0}}, inc};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (sum[M]) begin
      exp_r = exp + (E+1)'(1);
      sig_r = sum[M:1];
    end else if (exp == '0) begin
      exp_r = {{E{1'b0}}, sum[M-1]};
      sig_r = sum[M-1:0];
    end else begin
      exp_r = exp;
      sig_r = sum[M-1:0];
    end

    overflow = exp_r >= {1'b0, {E{1'b1}}};
    inexact  = lost | overflow;

    if (overflow) begin
      if (to_inf) res = {sign, {E{1'b1}}, {(M-1){1'b0}}};
      else        res = {sign, {(E-1){1'b1}}, 1'b0, {(M-1){1'b1}}};
    end else begin
      res = {sign, exp_r[E-1:0], sig_r[M-2:0]};
    end
  end

endmodule

// File: rtl/fp_multiply_nr_pipe.sv
// rtl/fp_multiply_nr_pipe.sv - four-stage IEEE-754 multiplier with rounding, tags and sticky flags
module fp_multiply_nr_pipe
  import fpNPkg::*;
#(
  parameter int FPWID = 64,
  parameter int EMSB  = 10,
  parameter int FMSB  = 51,
  parameter int TAGW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  input  logic [2:0]       rm,
  input  logic [TAGW-1:0]  tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FPWID-1:0] o,
  output logic [TAGW-1:0]  tag_o,
  output logic [4:0]       flags_o,
  input  logic             clr_flags,
  output logic [4:0]       flags_acc
);

  localparam int E   = EMSB + 1;
  localparam int M   = FMSB + 2;
  localparam int W2  = 2 * M;
  localparam int XW  = EMSB + 4;
  localparam int LZW = $clog2(W2 + 1);
  localparam logic [E-1:0]     BIAS = {1'b0, {EMSB{1'b1}}};
  localparam logic [FPWID-1:0] QNAN = FPWID'(canon_qnan(EMSB, FMSB));

  typedef struct packed {
    logic            sign;
    logic [EMSB:0]   exp;
    logic [FMSB:0]   frac;
  } fp_t;

  // Special-case outcome, rounding mode and tag ride alongside the datapath.
  typedef struct packed {
    logic            sign;
    logic            nan;
    logic            inv;
    logic            inf;
    logic            zero;
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
  } ctl_t;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  fp_t  fa, fb;
  logic a_ez, a_eo, a_fz, a_zero, a_inf, a_nan, a_snan;
  logic b_ez, b_eo, b_fz, b_zero, b_inf, b_nan, b_snan;
  ctl_t s0_ctl;

  assign fa     = a;
  assign fb     = b;
  assign a_ez   = fa.exp == '0;
  assign a_eo   = &fa.exp;
  assign a_fz   = fa.frac == '0;
  assign a_zero = a_ez & a_fz;
  assign a_inf  = a_eo & a_fz;
  assign a_nan  = a_eo & ~a_fz;
  assign a_snan = a_nan & ~fa.frac[FMSB];
  assign b_ez   = fb.exp == '0;
  assign b_eo   = &fb.exp;
  assign b_fz   = fb.frac == '0;
  assign b_zero = b_ez & b_fz;
  assign b_inf  = b_eo & b_fz;
  assign b_nan  = b_eo & ~b_fz;
  assign b_snan = b_nan & ~fb.frac[FMSB];

  always_comb begin
    s0_ctl.sign = fa.sign ^ fb.sign;
    s0_ctl.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    s0_ctl.inv  = a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
    s0_ctl.inf  = (a_inf | b_inf) & ~s0_ctl.nan;
    s0_ctl.zero = (a_zero | b_zero) & ~s0_ctl.nan & ~s0_ctl.inf;
    s0_ctl.rm   = rm;
    s0_ctl.tag  = tag_i;
  end

  logic          s1_v, s2_v, s3_v;
  ctl_t          s1_ctl, s2_ctl, s3_ctl;
  logic [E-1:0]  s1_ea, s1_eb;
  logic [M-1:0]  s1_ma, s1_mb;
  logic [W2-1:0] s2_prod;
  logic [E+1:0]  s2_exp;
  logic [E:0]    s3_exp;
  logic [M-1:0]  s3_sig;
  logic          s3_g, s3_r, s3_s, s3_tiny;

  // Normalise: left-justify the product, then denormalise tiny results into the subnormal range.
  logic [LZW-1:0] lz;
  logic [W2-1:0]  pl, norm, lost_mask;
  logic [XW-1:0]  exp_n, rs;
  logic           tiny, lost;

  always_comb begin
    lz = LZW'(W2);
    for (int i = 0; i < W2; i++) if (s2_prod[i]) lz = LZW'(W2 - 1 - i);
    pl        = s2_prod << lz;
    exp_n     = {s2_exp[E+1], s2_exp} + XW'(1) - XW'(lz);
    tiny      = exp_n[XW-1] | (exp_n == '0);
    rs        = XW'(1) - exp_n;
    norm      = pl;
    lost      = 1'b0;
    lost_mask = '0;
    if (tiny) begin
      if (rs >= XW'(W2)) begin
        norm = '0;
        lost = |pl;
      end else begin
        norm      = pl >> rs;
        lost_mask = ~({W2{1'b1}} << rs);
        lost      = |(pl & lost_mask);
      end
    end
  end

  logic [FPWID-1:0] rp_res, s4_res;
  logic             rp_of, rp_nx;
  logic [4:0]       s4_flags;

  fp_round_pack #(
    .EMSB  (EMSB),
    .FMSB  (FMSB),
    .FPWID (FPWID)
  ) u_round (
    .sign     (s3_ctl.sign),
    .exp      (s3_exp),
    .sig      (s3_sig),
    .g        (s3_g),
    .r        (s3_r),
    .s        (s3_s),
    .rm       (s3_ctl.rm),
    .res      (rp_res),
    .overflow (rp_of),
    .inexact  (rp_nx)
  );

  always_comb begin
    s4_res   = rp_res;
    s4_flags = '0;
    if (s3_ctl.nan) begin
      s4_res            = QNAN;
      s4_flags[FLAG_NV] = s3_ctl.inv;
    end else if (s3_ctl.inf) begin
      s4_res = {s3_ctl.sign, {E{1'b1}}, {(M-1){1'b0}}};
    end else if (s3_ctl.zero) begin
      s4_res = {s3_ctl.sign, {(FPWID-1){1'b0}}};
    end else begin
      s4_flags[FLAG_OF] = rp_of;
      s4_flags[FLAG_UF] = s3_tiny & rp_nx;
      s4_flags[FLAG_NX] = rp_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
      s1_ctl    <= '0;
      s2_ctl    <= '0;
      s3_ctl    <= '0;
      s1_ea     <= '0;
      s1_eb     <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s2_prod   <= '0;
      s2_exp    <= '0;
      s3_exp    <= '0;
      s3_sig    <= '0;
      s3_g      <= 1'b0;
      s3_r      <= 1'b0;
      s3_s      <= 1'b0;
      s3_tiny   <= 1'b0;
      o         <= '0;
      tag_o     <= '0;
      flags_o   <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_ctl    <= s0_ctl;
      s1_ea     <= a_ez ? E'(1) : fa.exp;
      s1_eb     <= b_ez ? E'(1) : fb.exp;
      s1_ma     <= {~a_ez, fa.frac};
      s1_mb     <= {~b_ez, fb.frac};
      s2_v      <= s1_v;
      s2_ctl    <= s1_ctl;
      s2_prod   <= W2'(s1_ma) * W2'(s1_mb);
      s2_exp    <= (E+2)'(s1_ea) + (E+2)'(s1_eb) - (E+2)'(BIAS);
      s3_v      <= s2_v;
      s3_ctl    <= s2_ctl;
      s3_exp    <= tiny ? '0 : exp_n[E:0];
      s3_sig    <= norm[W2-1:M];
      s3_g      <= norm[M-1];
      s3_r      <= norm[M-2];
      s3_s      <= (|norm[M-3:0]) | lost;
      s3_tiny   <= tiny;
      out_valid <= s3_v;
      o         <= s4_res;
      tag_o     <= s3_ctl.tag;
      flags_o   <= s4_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      flags_acc <= '0;
    else if (clr_flags)              flags_acc <= (out_valid & out_ready) ? flags_o : '0;
    else if (out_valid & out_ready)  flags_acc <= flags_acc | flags_o;
  end

endmodule

// File: tb/tb_fp_multiply_nr_pipe.sv
// tb/tb_fp_multiply_nr_pipe.sv - directed-vector bench for the binary64 multiply pipe
module tb_fp_multiply_nr_pipe;

  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic [2:0]  rm;
  logic [7:0]  tag_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] o;
  logic [7:0]  tag_o;
  logic [4:0]  flags_o;
  logic        clr_flags;
  logic [4:0]  flags_acc;

  fp_multiply_nr_pipe #(.FPWID(64), .EMSB(10), .FMSB(51), .TAGW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rm        (rm),
    .tag_i     (tag_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .tag_o     (tag_o),
    .flags_o   (flags_o),
    .clr_flags (clr_flags),
    .flags_acc (flags_acc)
  );

  always #5 clk = ~clk;

  logic [63:0] va [NV];
  logic [63:0] vb [NV];
  logic [63:0] vo [NV];
  logic [2:0]  vrm[NV];
  logic [4:0]  vf [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [63:0] xa, input logic [63:0] xb,
                         input logic [2:0] xrm, input logic [63:0] xo, input logic [4:0] xf);
    va[i] = xa; vb[i] = xb; vrm[i] = xrm; vo[i] = xo; vf[i] = xf;
  endtask

  // Single op with out_ready held high; checks latency and the result fields.
  task automatic run_op(input int i, input logic [7:0] t);
    int lat;
    a = va[i]; b = vb[i]; rm = vrm[i]; tag_i = t;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check_eq($sformatf("in_ready[%0d]", i), 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check_eq($sformatf("latency[%0d]", i), 64'(lat), 64'd4);
    check_eq($sformatf("o[%0d]", i), o, vo[i]);
    check_eq($sformatf("flags[%0d]", i), 64'(flags_o), 64'(vf[i]));
    check_eq($sformatf("tag[%0d]", i), 64'(tag_o), 64'(t));
  endtask

  initial begin
    logic [4:0] acc_exp;
    int idx, got, cyc, stale;
    logic [3:0] pat;

    set_vec(0,  64'h3FF8000000000000, 64'h4000000000000000, 3'd0, 64'h4008000000000000, 5'h00);
    set_vec(1,  64'h7FF0000000000000, 64'h0000000000000000, 3'd0, 64'h7FF8000000000000, 5'h10);
    set_vec(2,  64'h7FF0000000000001, 64'h3FF0000000000000, 3'd0, 64'h7FF8000000000000, 5'h10);
    set_vec(3,  64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd0, 64'h7FF0000000000000, 5'h05);
    set_vec(4,  64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd1, 64'h7FEFFFFFFFFFFFFF, 5'h05);
    set_vec(5,  64'h0000000000000001, 64'h3FE0000000000000, 3'd0, 64'h0000000000000000, 5'h03);
    set_vec(6,  64'h0000000000000001, 64'h3FE0000000000000, 3'd3, 64'h0000000000000001, 5'h03);
    set_vec(7,  64'h0010000000000000, 64'h3FE0000000000000, 3'd0, 64'h0008000000000000, 5'h00);
    set_vec(8,  64'h7FF8000000000000, 64'h3FF0000000000000, 3'd0, 64'h7FF8000000000000, 5'h00);
    set_vec(9,  64'hFFF0000000000000, 64'h4000000000000000, 3'd0, 64'hFFF0000000000000, 5'h00);
    set_vec(10, 64'h8000000000000000, 64'h3FF0000000000000, 3'd0, 64'h8000000000000000, 5'h00);
    set_vec(11, 64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd2, 64'hFFF0000000000000, 5'h05);
    set_vec(12, 64'hFFEFFFFFFFFFFFFF, 64'h4000000000000000, 3'd3, 64'hFFEFFFFFFFFFFFFF, 5'h05);
    set_vec(13, 64'h3FF0000000000001, 64'h3FF8000000000000, 3'd0, 64'h3FF8000000000002, 5'h01);
    set_vec(14, 64'h3FF0000000000001, 64'h3FF8000000000000, 3'd1, 64'h3FF8000000000001, 5'h01);
    set_vec(15, 64'h3FF0000000000001, 64'h3FF8000000000000, 3'd4, 64'h3FF8000000000002, 5'h01);
    set_vec(16, 64'h3FF0000000000001, 64'h3FF8000000000000, 3'd7, 64'h3FF8000000000002, 5'h01);

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; rm = '0; tag_i = '0;
    out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_o", o, 64'd0);
    check_eq("rst_tag_o", 64'(tag_o), 64'd0);
    check_eq("rst_flags_o", 64'(flags_o), 64'd0);
    check_eq("rst_flags_acc", 64'(flags_acc), 64'd0);
    rst_n = 1'b1;
    #1 check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    acc_exp = '0;
    for (int i = 0; i < NV; i++) begin
      run_op(i, 8'(i + 64));
      acc_exp = acc_exp | vf[i];
    end
    @(posedge clk); @(negedge clk);
    check_eq("acc_directed", 64'(flags_acc), 64'(acc_exp));

    clr_flags = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_flags = 1'b0;
    check_eq("acc_cleared", 64'(flags_acc), 64'd0);

    pat = 4'b1001;
    idx = 0; got = 0; cyc = 0; acc_exp = '0;
    while (got < 8 && cyc < 200) begin
      out_ready = pat[3 - (cyc % 4)];
      if (idx < 8) begin
        in_valid = 1'b1; a = va[idx]; b = vb[idx]; rm = vrm[idx]; tag_i = 8'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check_eq("burst_in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        check_eq($sformatf("burst_tag[%0d]", got), 64'(tag_o), 64'(got));
        check_eq($sformatf("burst_o[%0d]", got), o, vo[got]);
        check_eq($sformatf("burst_flags[%0d]", got), 64'(flags_o), 64'(vf[got]));
        acc_exp = acc_exp | vf[got];
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("burst_count", 64'(got), 64'd8);
    check_eq("burst_drained", 64'(out_valid), 64'd0);
    check_eq("burst_acc", 64'(flags_acc), 64'(acc_exp));

    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k]; rm = vrm[k]; tag_i = 8'(128 + k); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_flags_acc", 64'(flags_acc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("midrst_stale", 64'(stale), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
